// File: rtl/lcd_ctrl_seq_if.sv
// Command and byte-driver handshake bundle for the LCD command sequencer.
// The sequencer takes the slave view; the command source / bus driver take the master view.
interface lcd_ctrl_seq_if;
   logic       cmd_valid;
   logic [2:0] cmd_op;
   logic [7:0] cmd_arg;
   logic       cmd_rdy;
   logic       cmd_err;
   logic       init_done;
   logic       drv_valid;
   logic       drv_rs;
   logic [7:0] drv_data;
   logic       drv_rdy;

   modport slave (
      input  cmd_valid, cmd_op, cmd_arg, drv_rdy,
      output cmd_rdy, cmd_err, init_done, drv_valid, drv_rs, drv_data
   );

   modport master (
      output cmd_valid, cmd_op, cmd_arg, drv_rdy,
      input  cmd_rdy, cmd_err, init_done, drv_valid, drv_rs, drv_data
   );
endinterface

// File: rtl/lcd_ctrl_seq.sv
// HD44780-class command sequencer: turns user ops into instruction/data bytes for the
// bus driver and times every controller execution delay from CLK_HZ.
module lcd_ctrl_seq #(
   parameter int unsigned CLK_HZ = 50_000_000,
   parameter int unsigned MODE   = 1,
   parameter int unsigned LINES  = 1,
   parameter int unsigned FONT   = 0,
   parameter int unsigned CNT_W  = 24
) (
   input logic           clk,
   input logic           rst,
   lcd_ctrl_seq_if.slave bus
);

   localparam int unsigned CyclesPerUs = CLK_HZ / 1_000_000;

   // Counter reload values are one less than the delay: the zero cycle is the last one.
   localparam logic [CNT_W-1:0] Load42   = CNT_W'(CyclesPerUs * 42 - 1);
   localparam logic [CNT_W-1:0] Load1640 = CNT_W'(CyclesPerUs * 1640 - 1);
   localparam logic [CNT_W-1:0] LoadPwr  = CNT_W'(CyclesPerUs * 15000 - 1);

   localparam logic       DlBit = (MODE == 0);
   localparam logic       NBit  = (LINES != 0);
   localparam logic       FBit  = (FONT != 0);
   localparam logic [7:0] ByteFunc   = {3'b001, DlBit, NBit, FBit, 2'b00};
   localparam logic [7:0] ByteEntry  = 8'h06;
   localparam logic [7:0] ByteDispOn = 8'h0C;
   localparam logic [7:0] ByteClear  = 8'h01;
   localparam logic [7:0] ByteHome   = 8'h02;
   localparam logic [7:0] ByteOff    = 8'h08;

   localparam logic [2:0] OpNop    = 3'd0;
   localparam logic [2:0] OpInit   = 3'd1;
   localparam logic [2:0] OpConfig = 3'd2;
   localparam logic [2:0] OpData   = 3'd3;
   localparam logic [2:0] OpClear  = 3'd4;
   localparam logic [2:0] OpHome   = 3'd5;
   localparam logic [2:0] OpAddr   = 3'd6;
   localparam logic [2:0] OpOff    = 3'd7;

   typedef enum logic [1:0] {StIdle, StPwrWait, StIssue, StExecWait} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pwr_ok_q, pwr_ok_d;
   logic             init_done_q, init_done_d;
   logic             err_q, err_d;
   logic             rs_q, rs_d;
   logic [7:0]       data_q, data_d;
   logic             init_q, init_d;
   logic [1:0]       step_q, step_d;
   logic             long_exec;

   // Returns {rs, byte} for every single-byte op.
   function automatic logic [8:0] op_byte(input logic [2:0] op, input logic [7:0] arg);
      logic [8:0] b;
      case (op)
         OpConfig: b = {1'b0, 5'b00001, arg[2:0]};
         OpData:   b = {1'b1, arg};
         OpClear:  b = {1'b0, ByteClear};
         OpHome:   b = {1'b0, ByteHome};
         OpAddr:   b = {1'b0, 1'b1, arg[6:0]};
         OpOff:    b = {1'b0, ByteOff};
         default:  b = 9'h000;
      endcase
      return b;
   endfunction

   function automatic logic [7:0] init_byte(input logic [1:0] step);
      logic [7:0] b;
      case (step)
         2'd0:    b = ByteFunc;
         2'd1:    b = ByteEntry;
         2'd2:    b = ByteDispOn;
         default: b = ByteClear;
      endcase
      return b;
   endfunction

   // Only CLEAR and HOME encode to 0x01/0x02 as instructions.
   assign long_exec = !rs_q && (data_q == ByteClear || data_q == ByteHome);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pwr_ok_d    = pwr_ok_q;
      init_done_d = init_done_q;
      err_d       = 1'b0;
      rs_d        = rs_q;
      data_d      = data_q;
      init_d      = init_q;
      step_d      = step_q;

      unique case (state_q)
         StIdle: begin
            if (bus.cmd_valid) begin
               if (bus.cmd_op == OpInit) begin
                  init_d = 1'b1;
                  step_d = 2'd0;
                  rs_d   = 1'b0;
                  data_d = init_byte(2'd0);
                  if (pwr_ok_q) begin
                     state_d = StIssue;
                  end else begin
                     state_d = StPwrWait;
                     cnt_d   = LoadPwr;
                  end
               end else if (bus.cmd_op != OpNop) begin
                  if (!init_done_q) begin
                     err_d = 1'b1;
                  end else begin
                     init_d           = 1'b0;
                     {rs_d, data_d}   = op_byte(bus.cmd_op, bus.cmd_arg);
                     state_d          = StIssue;
                  end
               end
            end
         end
         StPwrWait: begin
            if (cnt_q == '0) begin
               pwr_ok_d = 1'b1;
               state_d  = StIssue;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         StIssue: begin
            if (bus.drv_rdy) begin
               state_d = StExecWait;
               cnt_d   = long_exec ? Load1640 : Load42;
            end
         end
         StExecWait: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (init_q && step_q != 2'd3) begin
               step_d  = step_q + 2'd1;
               data_d  = init_byte(step_q + 2'd1);
               state_d = StIssue;
            end else begin
               state_d = StIdle;
               if (init_q) init_done_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         pwr_ok_q    <= 1'b0;
         init_done_q <= 1'b0;
         err_q       <= 1'b0;
         rs_q        <= 1'b0;
         data_q      <= 8'h00;
         init_q      <= 1'b0;
         step_q      <= 2'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pwr_ok_q    <= pwr_ok_d;
         init_done_q <= init_done_d;
         err_q       <= err_d;
         rs_q        <= rs_d;
         data_q      <= data_d;
         init_q      <= init_d;
         step_q      <= step_d;
      end
   end

   assign bus.cmd_rdy   = (state_q == StIdle);
   assign bus.cmd_err   = err_q;
   assign bus.init_done = init_done_q;
   assign bus.drv_valid = (state_q == StIssue);
   assign bus.drv_rs    = rs_q;
   assign bus.drv_data  = data_q;

endmodule

// File: tb/tb_lcd_ctrl_seq.sv
// Bench for lcd_ctrl_seq: random commands and driver stalls compared every cycle against a
// transaction-level model (byte queue plus countdown), with literal timing checks.
module tb_lcd_ctrl_seq;

   typedef struct packed {
      logic        rs;
      logic [7:0]  data;
      logic [15:0] gap;
   } rec_t;

   logic clk;
   logic rst;

   lcd_ctrl_seq_if bus ();
   lcd_ctrl_seq_if bus2 ();

   lcd_ctrl_seq #(.CLK_HZ(1_000_000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   lcd_ctrl_seq #(.CLK_HZ(1_000_000), .MODE(0), .LINES(0), .FONT(0)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   // Second build runs in lockstep with the first; only its FUNC byte differs.
   assign bus2.cmd_valid = bus.cmd_valid;
   assign bus2.cmd_op    = bus.cmd_op;
   assign bus2.cmd_arg   = bus.cmd_arg;
   assign bus2.drv_rdy   = bus.drv_rdy;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #990_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Model state
   bit   busy, m_done, m_pwr, m_err, m_init;
   int   hold;
   rec_t pend[$];

   // Logs for literal timing checks
   int          cyc = 0;
   int          vrise[$];
   int          xfer_cyc[$];
   logic [7:0]  xfer_dat[$];
   int          acc_last, rrise_last;
   bit          prev_valid, prev_rdy;

   function automatic rec_t op_rec(input logic [2:0] op, input logic [7:0] arg);
      case (op)
         3'd2:    return {1'b0, 5'b00001, arg[2:0], 16'd42};
         3'd3:    return {1'b1, arg, 16'd42};
         3'd4:    return {1'b0, 8'h01, 16'd1640};
         3'd5:    return {1'b0, 8'h02, 16'd1640};
         3'd6:    return {1'b0, 1'b1, arg[6:0], 16'd42};
         default: return {1'b0, 8'h08, 16'd42};
      endcase
   endfunction

   always @(negedge clk) begin
      bit e_valid;
      cyc++;
      if (!rst) begin
         busy = 0; m_done = 0; m_pwr = 0; m_err = 0; m_init = 0; hold = 0;
         pend.delete();
      end
      e_valid = busy && hold == 0 && pend.size() > 0;
      check("cmd_rdy", bus.cmd_rdy, !busy);
      check("cmd_err", bus.cmd_err, m_err);
      check("init_done", bus.init_done, m_done);
      check("drv_valid", bus.drv_valid, e_valid);
      if (e_valid) begin
         check("drv_rs", bus.drv_rs, pend[0].rs);
         check("drv_data", bus.drv_data, pend[0].data);
      end else if (!rst) begin
         check("rst_drv_rs", bus.drv_rs, 1'b0);
         check("rst_drv_data", bus.drv_data, 8'h00);
      end
      if (rst) begin
         if (e_valid && bus.drv_rdy && !pend[0].rs && pend[0].data == 8'h28) begin
            check("func_mode0_valid", bus2.drv_valid, 1'b1);
            check("func_mode0_data", bus2.drv_data, 8'h30);
         end
         if (bus.drv_valid && !prev_valid) vrise.push_back(cyc);
         if (bus.drv_valid && bus.drv_rdy) begin
            xfer_cyc.push_back(cyc);
            xfer_dat.push_back(bus.drv_data);
         end
         if (bus.cmd_rdy && !prev_rdy) rrise_last = cyc;
         if (bus.cmd_valid && bus.cmd_rdy) acc_last = cyc;
         prev_valid = bus.drv_valid;
         prev_rdy   = bus.cmd_rdy;

         m_err = 0;
         if (!busy) begin
            if (bus.cmd_valid && bus.cmd_op != 3'd0) begin
               if (bus.cmd_op == 3'd1) begin
                  pend.push_back({1'b0, 8'h28, 16'd42});
                  pend.push_back({1'b0, 8'h06, 16'd42});
                  pend.push_back({1'b0, 8'h0C, 16'd42});
                  pend.push_back({1'b0, 8'h01, 16'd1640});
                  busy = 1; m_init = 1;
                  hold = m_pwr ? 0 : 15000;
                  m_pwr = 1;
               end else if (!m_done) begin
                  m_err = 1;
               end else begin
                  pend.push_back(op_rec(bus.cmd_op, bus.cmd_arg));
                  busy = 1; m_init = 0; hold = 0;
               end
            end
         end else if (hold > 0) begin
            hold--;
            if (hold == 0 && pend.size() == 0) begin
               busy = 0;
               if (m_init) m_done = 1;
            end
         end else if (e_valid && bus.drv_rdy) begin
            hold = int'(pend[0].gap);
            void'(pend.pop_front());
         end
      end
   end

   // Bus driver model: random stall of 0..3 cycles, stray drv_rdy while idle.
   initial begin : driver
      int stall, waitn;
      bus.drv_rdy = 1'b0;
      stall = 0;
      waitn = 2;
      forever begin
         @(posedge clk); #1;
         if (!bus.drv_valid) begin
            stall = 0;
            waitn = $urandom_range(0, 3);
            bus.drv_rdy = ($urandom_range(0, 3) == 0);
         end else if (stall >= waitn) begin
            bus.drv_rdy = 1'b1;
         end else begin
            stall++;
            bus.drv_rdy = 1'b0;
         end
      end
   end

   task automatic clear_logs();
      vrise.delete();
      xfer_cyc.delete();
      xfer_dat.delete();
   endtask

   // Junk cmd_valid while busy must be ignored; one extra cycle lets the monitor log.
   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (!bus.cmd_rdy && n < budget) begin
         bus.cmd_valid = ($urandom_range(0, 7) == 0);
         bus.cmd_op    = 3'($urandom);
         bus.cmd_arg   = 8'($urandom);
         @(posedge clk); #1;
         n++;
      end
      bus.cmd_valid = 1'b0;
      check("idle_reached", bus.cmd_rdy, 1'b1);
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [2:0] op, input logic [7:0] arg);
      wait_idle(20000);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_arg   = arg;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 3'($urandom);
      bus.cmd_arg   = 8'($urandom);
   endtask

   task automatic one_byte(input string name, input logic [2:0] op, input logic [7:0] arg,
                           input logic [7:0] exp_data, input int exp_gap);
      clear_logs();
      send(op, arg);
      wait_idle(4000);
      check({name, "_nbytes"}, xfer_dat.size(), 1);
      if (xfer_dat.size() == 1) begin
         check({name, "_data"}, xfer_dat[0], exp_data);
         check({name, "_rdy_gap"}, rrise_last - xfer_cyc[0], exp_gap + 1);
      end
   endtask

   task automatic check_init(input string name, input int exp_first);
      logic [7:0] exp_b [4];
      exp_b[0] = 8'h28; exp_b[1] = 8'h06; exp_b[2] = 8'h0C; exp_b[3] = 8'h01;
      check({name, "_nbytes"}, xfer_dat.size(), 4);
      check({name, "_nrise"}, vrise.size(), 4);
      if (xfer_dat.size() == 4 && vrise.size() == 4) begin
         check({name, "_first_latency"}, vrise[0] - acc_last, exp_first);
         for (int i = 0; i < 4; i++) check({name, "_byte"}, xfer_dat[i], exp_b[i]);
         for (int i = 0; i < 3; i++) check({name, "_gap"}, vrise[i+1] - xfer_cyc[i], 43);
         check({name, "_done_gap"}, rrise_last - xfer_cyc[3], 1641);
      end
      check({name, "_init_done"}, bus.init_done, 1'b1);
   endtask

   initial begin : stim
      rst           = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 3'd0;
      bus.cmd_arg   = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("reset_cmd_rdy", bus.cmd_rdy, 1'b1);
      check("reset_drv_valid", bus.drv_valid, 1'b0);
      check("reset_init_done", bus.init_done, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Data before INIT is rejected
      send(3'd3, 8'h41);
      check("early_err", bus.cmd_err, 1'b1);
      check("early_valid", bus.drv_valid, 1'b0);
      check("early_rdy", bus.cmd_rdy, 1'b1);
      @(posedge clk); #1;
      check("early_err_pulse", bus.cmd_err, 1'b0);

      // First INIT with power wait
      clear_logs();
      send(3'd1, 8'h00);
      wait_idle(20000);
      check_init("init1", 15001);

      one_byte("data41", 3'd3, 8'h41, 8'h41, 42);
      one_byte("addr40", 3'd6, 8'h40, 8'hC0, 42);
      one_byte("config7", 3'd2, 8'h07, 8'h0F, 42);
      one_byte("off", 3'd7, 8'h5A, 8'h08, 42);
      one_byte("home", 3'd5, 8'h00, 8'h02, 1640);
      one_byte("clear", 3'd4, 8'h00, 8'h01, 1640);

      // Second INIT skips the power wait
      clear_logs();
      send(3'd1, 8'h00);
      wait_idle(4000);
      check_init("init2", 1);

      for (int i = 0; i < 30; i++) begin
         send(3'($urandom_range(0, 7)), 8'($urandom));
      end
      wait_idle(4000);

      // Reset in the middle of a CLEAR execution wait
      send(3'd4, 8'h00);
      repeat (200) @(posedge clk);
      #1;
      check("clr_exec_valid", bus.drv_valid, 1'b0);
      check("clr_exec_rdy", bus.cmd_rdy, 1'b0);
      rst = 1'b0;
      #1;
      check("midrst_cmd_rdy", bus.cmd_rdy, 1'b1);
      check("midrst_init_done", bus.init_done, 1'b0);
      check("midrst_drv_valid", bus.drv_valid, 1'b0);
      check("midrst_drv_data", bus.drv_data, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      send(3'd3, 8'h41);
      check("postrst_err", bus.cmd_err, 1'b1);
      check("postrst_valid", bus.drv_valid, 1'b0);
      repeat (5) @(posedge clk);
      #1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
